// File: rtl/lane_tx_scheduler.sv
// Round-robin scheduler that shares one byte lane among four requesters.
// After reset it emits a run of COM symbols, then grants bursts of up to MAX_BURST bytes.
module lane_tx_scheduler #(
  parameter int         SYNC_COUNT = 4,
  parameter int         MAX_BURST  = 8,
  parameter logic [7:0] COM_SYMBOL = 8'hBC
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic [1:0]  grant_id,
  output logic        sync_done
);

  localparam int SC_W = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [SC_W-1:0] SYNC_LAST  = SC_W'(SYNC_COUNT - 1);
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {SYNC, IDLE, BURST} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        data_out_reg, data_out_next;
  logic              valid_out_reg, valid_out_next;
  logic [1:0]        grant_id_reg, grant_id_next;
  logic              sync_done_reg, sync_done_next;
  logic [1:0]        rr_ptr_reg, rr_ptr_next;
  logic [SC_W-1:0]   sync_cnt_reg, sync_cnt_next;
  logic [BC_W-1:0]   burst_cnt_reg, burst_cnt_next;

  logic [7:0]        lane_byte [4];
  logic [3:0]        req_rot;
  logic [1:0]        rot_off;
  logic [1:0]        winner;
  logic              burst_last;

  // Requests rotated so bit 0 is the requester at rr_ptr; ready is pure state decode.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = req_data[8*gi +: 8];
      assign req_rot[gi]   = req_valid[2'(rr_ptr_reg + 2'(gi))];
      assign req_ready[gi] = (state_reg == BURST) && (grant_id_reg == 2'(gi));
    end
  endgenerate

  always_comb begin
    rot_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) rot_off = 2'(k);
    end
  end

  assign winner     = rr_ptr_reg + rot_off;
  assign burst_last = (burst_cnt_reg == BURST_LAST);

  always_comb begin
    state_next     = state_reg;
    data_out_next  = COM_SYMBOL;
    valid_out_next = 1'b0;
    grant_id_next  = grant_id_reg;
    sync_done_next = sync_done_reg;
    rr_ptr_next    = rr_ptr_reg;
    sync_cnt_next  = sync_cnt_reg;
    burst_cnt_next = burst_cnt_reg;
    unique case (state_reg)
      SYNC: begin
        sync_cnt_next = sync_cnt_reg + 1'b1;
        if (sync_cnt_reg == SYNC_LAST) begin
          state_next     = IDLE;
          sync_done_next = 1'b1;
        end
      end
      IDLE: begin
        if (|req_valid) begin
          grant_id_next  = winner;
          burst_cnt_next = '0;
          state_next     = BURST;
        end
      end
      BURST: begin
        if (req_valid[grant_id_reg]) begin
          data_out_next  = lane_byte[grant_id_reg];
          valid_out_next = 1'b1;
          burst_cnt_next = burst_last ? '0 : burst_cnt_reg + 1'b1;
          if (burst_last) begin
            state_next  = IDLE;
            rr_ptr_next = grant_id_reg + 2'd1;
          end
        end else begin
          // Requester went quiet: close the burst and move priority past it.
          state_next  = IDLE;
          rr_ptr_next = grant_id_reg + 2'd1;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_reg     <= SYNC;
      data_out_reg  <= COM_SYMBOL;
      valid_out_reg <= 1'b0;
      grant_id_reg  <= 2'd0;
      sync_done_reg <= 1'b0;
      rr_ptr_reg    <= 2'd0;
      sync_cnt_reg  <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      data_out_reg  <= data_out_next;
      valid_out_reg <= valid_out_next;
      grant_id_reg  <= grant_id_next;
      sync_done_reg <= sync_done_next;
      rr_ptr_reg    <= rr_ptr_next;
      sync_cnt_reg  <= sync_cnt_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;
  assign grant_id  = grant_id_reg;
  assign sync_done = sync_done_reg;

endmodule

// File: tb/tb_lane_tx_scheduler.sv
// Bench for lane_tx_scheduler: two instances (MAX_BURST 8 and 1) checked every cycle
// against a transaction-level reference model, plus directed scenario checks.
module tb_lane_tx_scheduler;

  localparam int         SYNC_COUNT = 4;
  localparam logic [7:0] COM        = 8'hBC;

  logic             clk_4f;
  logic             reset;
  logic [1:0][3:0]  req_valid;
  logic [1:0][31:0] req_data;
  logic [1:0][3:0]  req_ready;
  logic [1:0][7:0]  dout;
  logic [1:0]       vout;
  logic [1:0][1:0]  gid;
  logic [1:0]       sdone;

  lane_tx_scheduler #(.SYNC_COUNT(SYNC_COUNT), .MAX_BURST(8), .COM_SYMBOL(COM)) u_dut0 (
    .clk_4f(clk_4f), .reset(reset), .req_valid(req_valid[0]), .req_data(req_data[0]),
    .req_ready(req_ready[0]), .data_out(dout[0]), .valid_out(vout[0]),
    .grant_id(gid[0]), .sync_done(sdone[0]));

  lane_tx_scheduler #(.SYNC_COUNT(SYNC_COUNT), .MAX_BURST(1), .COM_SYMBOL(COM)) u_dut1 (
    .clk_4f(clk_4f), .reset(reset), .req_valid(req_valid[1]), .req_data(req_data[1]),
    .req_ready(req_ready[1]), .data_out(dout[1]), .valid_out(vout[1]),
    .grant_id(gid[1]), .sync_done(sdone[1]));

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the lane, how many bytes it has sent, who is next in line.
  int         mb [2] = '{8, 1};
  int         m_sync_seen [2];
  bit         m_synced [2];
  int         m_owner [2];
  int         m_first [2];
  int         m_taken [2];
  int         m_gid [2];
  logic [7:0] m_data [2];
  bit         m_valid [2];

  // Byte sources: each requester offers an incrementing byte stream of finite length.
  logic [7:0] src_byte [2][4];
  int         src_left [2][4];
  int         pct [2];

  bit         prev_v [2];
  int         vcnt [2];
  int         glog0 [$];
  int         glog1 [$];
  int         exp3 [5] = '{0, 1, 2, 3, 0};
  int         exp6 [4] = '{1, 3, 1, 3};

  task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s unit%0d observed=%0h expected=%0h", tag, u, obs, exp);
    end
  endtask

  function automatic int glog_at(input int u, input int k);
    if (u == 0) return (k < glog0.size()) ? glog0[k] : -1;
    return (k < glog1.size()) ? glog1[k] : -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_sync_seen[u] = 0;
      m_synced[u]    = 0;
      m_owner[u]     = -1;
      m_first[u]     = 0;
      m_taken[u]     = 0;
      m_gid[u]       = 0;
      m_data[u]      = COM;
      m_valid[u]     = 0;
    end
  endtask

  task automatic model_step(input int u);
    logic [3:0] v;
    int g, w, idx;
    v = req_valid[u];
    m_data[u]  = COM;
    m_valid[u] = 0;
    if (!m_synced[u]) begin
      m_sync_seen[u]++;
      if (m_sync_seen[u] == SYNC_COUNT) m_synced[u] = 1;
    end else if (m_owner[u] < 0) begin
      if (v != 4'b0000) begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          idx = (m_first[u] + k) % 4;
          if (w < 0 && v[idx]) w = idx;
        end
        m_owner[u] = w;
        m_gid[u]   = w;
        m_taken[u] = 0;
      end
    end else begin
      g = m_owner[u];
      if (v[g]) begin
        m_data[u]  = src_byte[u][g];
        m_valid[u] = 1;
        m_taken[u]++;
        src_byte[u][g] = src_byte[u][g] + 8'd1;
        src_left[u][g]--;
        if (m_taken[u] == mb[u]) begin
          m_owner[u] = -1;
          m_first[u] = (g + 1) % 4;
        end
      end else begin
        m_owner[u] = -1;
        m_first[u] = (g + 1) % 4;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_rdy;
    for (int u = 0; u < 2; u++) begin
      exp_rdy = (m_owner[u] >= 0) ? (4'b0001 << m_owner[u]) : 4'b0000;
      chk("data_out", u, 32'(dout[u]), 32'(m_data[u]));
      chk("valid_out", u, 32'(vout[u]), 32'(m_valid[u]));
      chk("req_ready", u, 32'(req_ready[u]), 32'(exp_rdy));
      chk("grant_id", u, 32'(gid[u]), 32'(m_gid[u]));
      chk("sync_done", u, 32'(sdone[u]), 32'(m_synced[u]));
      if (vout[u] === 1'b1 && !prev_v[u]) begin
        if (u == 0) glog0.push_back(int'(gid[u]));
        else        glog1.push_back(int'(gid[u]));
      end
      if (vout[u] === 1'b1) vcnt[u]++;
      prev_v[u] = (vout[u] === 1'b1);
    end
  endtask

  task automatic drive();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[u][i]       = (src_left[u][i] > 0) && (int'($urandom_range(0, 99)) < pct[u]);
        req_data[u][8*i +: 8] = src_byte[u][i];
      end
    end
  endtask

  // Check the state left by the last edge, present new inputs, predict the next edge.
  task automatic cycle();
    check_all();
    drive();
    if (!reset) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk_4f);
  endtask

  // Reset lands mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input int hold);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    repeat (hold) @(negedge clk_4f);
    reset = 1'b0;
  endtask

  task automatic clear_sources();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 4; i++) begin
        src_left[u][i] = 0;
        src_byte[u][i] = 8'($urandom);
      end
      pct[u] = 100;
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    for (int u = 0; u < 2; u++) begin
      prev_v[u] = 0;
      vcnt[u]   = 0;
    end
    model_reset();
    clear_sources();
    repeat (2) @(negedge clk_4f);
    reset = 1'b0;

    // Sync run with nobody requesting.
    repeat (8) cycle();

    // Single requester streaming ten bytes.
    vcnt[0] = 0;
    glog0.delete();
    src_left[0][0] = 10;
    src_byte[0][0] = 8'h01;
    repeat (30) cycle();
    chk("t2_bytes", 0, 32'(vcnt[0]), 32'd10);
    chk("t2_grants", 0, 32'(glog0.size()), 32'd2);

    // All four saturating from rr_ptr=0.
    do_reset(2);
    clear_sources();
    for (int i = 0; i < 4; i++) src_left[0][i] = 100;
    glog0.delete();
    repeat (50) cycle();
    chk("t3_grants_n", 0, 32'(glog0.size()), 32'd5);
    for (int k = 0; k < 5; k++) chk("t3_grant", 0, 32'(glog_at(0, k)), 32'(exp3[k]));

    // Early drop by requester 2 with 3 pending; MAX_BURST=1 alternation on unit 1.
    do_reset(2);
    clear_sources();
    src_left[0][2] = 3;
    src_left[0][3] = 20;
    src_left[1][1] = 30;
    src_left[1][3] = 30;
    glog0.delete();
    glog1.delete();
    repeat (30) cycle();
    chk("t4_first", 0, 32'(glog_at(0, 0)), 32'd2);
    chk("t4_next", 0, 32'(glog_at(0, 1)), 32'd3);
    for (int k = 0; k < 4; k++) chk("t6_grant", 1, 32'(glog_at(1, k)), 32'(exp6[k]));

    // Reset in the middle of a burst.
    do_reset(2);
    clear_sources();
    src_left[0][0] = 50;
    repeat (6) cycle();
    vcnt[0] = 0;
    for (int k = 0; k < 60 && vcnt[0] < 5; k++) cycle();
    chk("t5_bytes", 0, 32'(vcnt[0]), 32'd5);
    do_reset(2);
    repeat (12) cycle();

    // Randomized traffic with resets landing wherever they fall.
    for (int s = 0; s < 6; s++) begin
      for (int u = 0; u < 2; u++) begin
        pct[u] = int'($urandom_range(30, 100));
        for (int i = 0; i < 4; i++) begin
          src_left[u][i] = int'($urandom_range(0, 20));
          src_byte[u][i] = 8'($urandom);
        end
      end
      repeat ($urandom_range(40, 120)) cycle();
      do_reset(int'($urandom_range(1, 3)));
    end
    repeat (10) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
